iob_vga_timing: RTL and testbench
=================================

// Module: iob_vga_timing
// PURPOSE
//  Pixel-timing front end for the Pong display path. Generates the 640x480@60Hz
//  raster (pixel_x/pixel_y, hsync, vsync, video_on) from the system clock via a
//  pixel-enable divider.
//  Drives the image-memory block's pixel coordinate inputs and takes back its
//  12-bit RGB, blanking it outside the active area. Outputs go to the VGA pins.
// PARAMETERS
//  CLK_DIV   4    clk cycles per pixel (100 MHz -> 25 MHz pixel rate); >=1
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   hsync pulse width, pixels
//  H_BP      48   horizontal back porch, pixels (H_TOTAL=800)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vsync pulse width, lines
//  V_BP      33   vertical back porch, lines (V_TOTAL=525)
//  SYNC_POL  0    sync active level (0 = active-low, standard for 640x480)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  en           in   1   timing run enable; low freezes all state
//  pixel_tick   out  1   one-clk strobe, one per pixel period
//  pixel_x      out  10  current horizontal count 0..H_TOTAL-1 (to IM)
//  pixel_y      out  10  current vertical count 0..V_TOTAL-1 (to IM)
//  rgb_in       in   12  colour from IM for (pixel_x,pixel_y), combinational
//  rgb_out      out  12  blanked, registered colour to VGA DAC
//  hsync        out  1   horizontal sync, level per SYNC_POL
//  vsync        out  1   vertical sync, level per SYNC_POL
//  video_on     out  1   registered active-area flag, aligned with rgb_out
//  frame_start  out  1   one-clk pulse when raster returns to (0,0)
// BEHAVIOUR
//  - One clock, clk; rst synchronous active-high, takes priority over en.
//  - Reset values: div_cnt=0, pixel_x=0, pixel_y=0, pixel_tick=0, rgb_out=0,
//    video_on=0, frame_start=0, hsync=vsync=~SYNC_POL (inactive).
//  - Divider: div_cnt counts 0..CLK_DIV-1 while en; pixel_tick=1 (registered)
//    in the clk where div_cnt==CLK_DIV-1, else 0. CLK_DIV=1 -> tick every clk.
//  - On pixel_tick: pixel_x increments; at H_TOTAL-1 wraps to 0 and pixel_y
//    increments; pixel_y at V_TOTAL-1 wraps to 0 on the same tick.
//  - pixel_x/pixel_y are raw counters (blanking values visible); IM decodes.
//  - Output stage, updated on the same tick as counters, from pre-update counts:
//    video_on <= (x<H_ACTIVE)&&(y<V_ACTIVE); rgb_out <= video_on_next ? rgb_in : 0;
//    hsync <= (x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]) ? SYNC_POL : ~SYNC_POL;
//    vsync <= (y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]) ? SYNC_POL : ~SYNC_POL.
//    => rgb_out/hsync/vsync/video_on lag pixel_x/y by exactly one pixel period,
//    mutually aligned. hsync low x=656..751, vsync low y=490..491 (defaults).
//  - frame_start=1 for the single clk after the tick that wraps (799,524)->(0,0).
//  - en low: div_cnt, counters and all outputs hold; pixel_tick and
//    frame_start forced 0. Resume continues from held div_cnt.
//  - Widths: counters 10 bits; comparisons unsigned; no overflow (max 799).
//  - Reset mid-frame: all state returns to reset values next clk; first
//    pixel_tick CLK_DIV clks after rst deasserts (with en=1).
// TESTING
//  1 rst 3 clks, en=1, CLK_DIV=4 -> reset values held; first pixel_tick 4th clk
//    after deassert; pixel_x=1 after it.
//  2 Run one line -> pixel_x 0..799 then 0, line period 3200 clks; hsync low
//    exactly 96 ticks, first low on tick after pixel_x=656 presented.
//  3 Run 2 frames -> frame_start pulses 1,680,000 clks apart; vsync low 2 lines
//    (1600 ticks) per frame; pixel_y never exceeds 524.
//  4 rgb_in=12'hFFF constant -> rgb_out=12'hFFF for 307200 ticks/frame, 0
//    elsewhere; video_on high count equals 307200.
//  5 Drop en at pixel_x=100 for 50 clks -> no ticks, all outputs frozen;
//    on re-assert pixel_x=101 within CLK_DIV clks.
//  6 Assert rst at pixel_y=300 -> next clk pixel_x=pixel_y=0, hsync=vsync=1,
//    rgb_out=0, no frame_start pulse.

Source files
------------

// File: rtl/iob_vga_timing.sv
// Raster timing generator for the VGA path: pixel-enable divider, raw x/y counters,
// and a registered, blanked colour/sync stage that lags the counters by one pixel.
module iob_vga_timing #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        pixel_tick,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  input  logic [11:0] rgb_in,
  output logic [11:0] rgb_out,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic       SYNC_ON   = (SYNC_POL != 0);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic             tick_q, tick_d;
  logic             fs_q, fs_d;
  logic             video_on_q, video_on_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;

  logic step;
  logic active_now;
  logic in_hsync;
  logic in_vsync;

  assign step       = en && (div_cnt_q == DIV_LAST);
  assign active_now = (x_q < H_ACT) && (y_q < V_ACT);
  assign in_hsync   = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
  assign in_vsync   = (y_q >= VS_FIRST) && (y_q <= VS_LAST);

  always_comb begin
    div_cnt_d  = div_cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    tick_d     = 1'b0;
    fs_d       = 1'b0;
    video_on_d = video_on_q;
    rgb_d      = rgb_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;

    if (en) begin
      div_cnt_d = step ? '0 : div_cnt_q + 1'b1;
    end

    if (step) begin
      tick_d = 1'b1;
      if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d  = '0;
          fs_d = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end

      // Output stage samples the pixel being left, so it trails x/y by one pixel.
      video_on_d = active_now;
      rgb_d      = active_now ? rgb_in : 12'h000;
      hsync_d    = in_hsync ? SYNC_ON : ~SYNC_ON;
      vsync_d    = in_vsync ? SYNC_ON : ~SYNC_ON;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      x_q        <= '0;
      y_q        <= '0;
      tick_q     <= 1'b0;
      fs_q       <= 1'b0;
      video_on_q <= 1'b0;
      rgb_q      <= 12'h000;
      hsync_q    <= ~SYNC_ON;
      vsync_q    <= ~SYNC_ON;
    end else begin
      div_cnt_q  <= div_cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      tick_q     <= tick_d;
      fs_q       <= fs_d;
      video_on_q <= video_on_d;
      rgb_q      <= rgb_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
    end
  end

  assign pixel_tick  = tick_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign rgb_out     = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_iob_vga_timing.sv
// Bench for iob_vga_timing: a full-size 640x480 instance and a tiny-raster instance,
// both checked each cycle against a counting model derived from enabled-clock totals.
module tb_iob_vga_timing;

  typedef struct {
    int div; int ha; int hfp; int hsw; int hbp;
    int va; int vfp; int vsw; int vbp; bit pat;
  } tp_t;

  typedef struct {
    bit tick; bit hs; bit vs; bit vo; bit fs;
    int x; int y; logic [11:0] rgb;
  } ex_t;

  localparam tp_t P_DEF = '{div:4, ha:640, hfp:16, hsw:96, hbp:48,
                            va:480, vfp:10, vsw:2, vbp:33, pat:1'b1};
  localparam tp_t P_SML = '{div:1, ha:8, hfp:2, hsw:3, hbp:2,
                            va:6, vfp:1, vsw:2, vbp:1, pat:1'b0};

  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  logic        d_tick, d_hs, d_vs, d_vo, d_fs;
  logic [9:0]  d_x, d_y;
  logic [11:0] d_rgb_in, d_rgb;
  logic        s_tick, s_hs, s_vs, s_vo, s_fs;
  logic [9:0]  s_x, s_y;
  logic [11:0] s_rgb_in, s_rgb;

  assign d_rgb_in = {d_x[5:0], d_y[5:0]};
  assign s_rgb_in = 12'hFFF;

  iob_vga_timing dut (
    .clk(clk), .rst(rst), .en(en), .pixel_tick(d_tick), .pixel_x(d_x), .pixel_y(d_y),
    .rgb_in(d_rgb_in), .rgb_out(d_rgb), .hsync(d_hs), .vsync(d_vs),
    .video_on(d_vo), .frame_start(d_fs)
  );

  iob_vga_timing #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(0)
  ) dut_s (
    .clk(clk), .rst(rst), .en(en), .pixel_tick(s_tick), .pixel_x(s_x), .pixel_y(s_y),
    .rgb_in(s_rgb_in), .rgb_out(s_rgb), .hsync(s_hs), .vsync(s_vs),
    .video_on(s_vo), .frame_start(s_fs)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Model: everything follows from n = enabled clocks since reset.
  function automatic ex_t model(input tp_t p, input longint n, input bit act);
    ex_t e;
    longint ht, vt, fr, pc, pm, q, qx, qy;
    logic [5:0] lx, ly;
    ht = p.ha + p.hfp + p.hsw + p.hbp;
    vt = p.va + p.vfp + p.vsw + p.vbp;
    fr = ht * vt;
    pc = n / p.div;
    pm = pc % fr;
    e.x    = int'(pm % ht);
    e.y    = int'(pm / ht);
    e.tick = act && (n > 0) && (n % p.div == 0);
    e.fs   = e.tick && (pm == 0);
    if (pc == 0) begin
      e.vo = 1'b0; e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1;
    end else begin
      q  = (pc - 1) % fr;
      qx = q % ht;
      qy = q / ht;
      lx = qx[5:0];
      ly = qy[5:0];
      e.vo  = (qx < p.ha) && (qy < p.va);
      e.hs  = !((qx >= p.ha + p.hfp) && (qx < p.ha + p.hfp + p.hsw));
      e.vs  = !((qy >= p.va + p.vfp) && (qy < p.va + p.vfp + p.vsw));
      e.rgb = e.vo ? (p.pat ? {lx, ly} : 12'hFFF) : 12'h000;
    end
    return e;
  endfunction

  longint n_en = 0;
  bit     last_act = 1'b0;
  bit     mvalid = 1'b0;
  int     cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      n_en <= 0; last_act <= 1'b0; mvalid <= 1'b1;
    end else if (en) begin
      n_en <= n_en + 1; last_act <= 1'b1;
    end else begin
      last_act <= 1'b0;
    end
  end

  // Single compare process: both instances against the model every cycle.
  always @(negedge clk) begin
    ex_t e;
    if (mvalid) begin
      e = model(P_DEF, n_en, last_act);
      chk("d_tick", 32'(d_tick), 32'(e.tick));
      chk("d_x", 32'(d_x), 32'(e.x));
      chk("d_y", 32'(d_y), 32'(e.y));
      chk("d_hsync", 32'(d_hs), 32'(e.hs));
      chk("d_vsync", 32'(d_vs), 32'(e.vs));
      chk("d_video_on", 32'(d_vo), 32'(e.vo));
      chk("d_rgb", 32'(d_rgb), 32'(e.rgb));
      chk("d_frame_start", 32'(d_fs), 32'(e.fs));
      e = model(P_SML, n_en, last_act);
      chk("s_tick", 32'(s_tick), 32'(e.tick));
      chk("s_x", 32'(s_x), 32'(e.x));
      chk("s_y", 32'(s_y), 32'(e.y));
      chk("s_hsync", 32'(s_hs), 32'(e.hs));
      chk("s_vsync", 32'(s_vs), 32'(e.vs));
      chk("s_video_on", 32'(s_vo), 32'(e.vo));
      chk("s_rgb", 32'(s_rgb), 32'(e.rgb));
      chk("s_frame_start", 32'(s_fs), 32'(e.fs));
    end
  end

  // Event statistics for the literal expectations.
  int fs_n = 0, fs_time[2], vs_lo = 0, vo_n = 0, ff_n = 0, blank_bad = 0;
  int lz_n = 0, lz_time[2], hs_lo = 0, hs_fall_x = -1;
  logic       prev_hs = 1'b1;
  logic [9:0] prev_x = '0;

  always @(negedge clk) begin
    int nf, nl;
    if (mvalid) begin
      nf = fs_n + (s_fs ? 1 : 0);
      if (s_fs && fs_n < 2) fs_time[fs_n] <= cyc;
      fs_n <= nf;
      if (nf == 1 && s_tick) begin
        if (!s_vs) vs_lo <= vs_lo + 1;
        if (s_vo) vo_n <= vo_n + 1;
        if (s_rgb == 12'hFFF) ff_n <= ff_n + 1;
        if (!s_vo && s_rgb != 12'h000) blank_bad <= blank_bad + 1;
      end
      if (d_tick) begin
        nl = lz_n + (d_x == 10'd0 ? 1 : 0);
        if (d_x == 10'd0 && lz_n < 2) lz_time[lz_n] <= cyc;
        lz_n <= nl;
        if (nl == 1 && !d_hs) hs_lo <= hs_lo + 1;
        if (!d_hs && prev_hs && hs_fall_x < 0) hs_fall_x <= int'(prev_x);
        prev_hs <= d_hs;
        prev_x  <= d_x;
      end
    end
  end

  initial begin
    int k;
    logic [9:0] hx, hy, shx;
    logic [11:0] hrgb;
    logic hhs, hvo;

    rst = 1'b1; en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk("rst_x", 32'(d_x), 0);
    chk("rst_hsync", 32'(d_hs), 1);
    chk("rst_vsync", 32'(d_vs), 1);
    chk("rst_rgb", 32'(d_rgb), 0);
    chk("rst_tick", 32'(d_tick), 0);

    repeat (3) @(posedge clk);
    #1 chk("tick_before_4th", 32'(d_tick), 0);
    @(posedge clk);
    #1 chk("tick_on_4th", 32'(d_tick), 1);
    chk("x_after_first_tick", 32'(d_x), 1);
    chk("s_x_after_4_clks", 32'(s_x), 4);

    // Two frames of the tiny raster
    k = 0;
    while (fs_n < 2 && k < 1000) begin @(negedge clk); k++; end
    chk("s_two_frames_seen", 32'(fs_n >= 2), 1);
    chk("s_frame_period", 32'(fs_time[1] - fs_time[0]), 150);
    chk("s_vsync_low_ticks", 32'(vs_lo), 30);
    chk("s_video_on_ticks", 32'(vo_n), 48);
    chk("s_rgb_fff_ticks", 32'(ff_n), 48);
    chk("s_rgb_blank_leak", 32'(blank_bad), 0);

    // One full line of the 640x480 raster
    k = 0;
    while (lz_n < 2 && k < 8000) begin @(negedge clk); k++; end
    chk("d_two_lines_seen", 32'(lz_n >= 2), 1);
    chk("d_line_period", 32'(lz_time[1] - lz_time[0]), 3200);
    chk("d_hsync_low_ticks", 32'(hs_lo), 96);
    chk("d_hsync_fall_after_x", 32'(hs_fall_x), 656);

    // Freeze with en low at pixel_x=100
    k = 0;
    while (!(d_tick && d_x == 10'd100) && k < 4000) begin @(negedge clk); k++; end
    chk("d_reach_x100", 32'(d_x), 100);
    @(posedge clk);
    #2 en = 1'b0;
    @(posedge clk);
    #1 hx = d_x; hy = d_y; hrgb = d_rgb; hhs = d_hs; hvo = d_vo; shx = s_x;
    repeat (49) @(posedge clk);
    #1 chk("hold_x", 32'(d_x), 32'(hx));
    chk("hold_x_is_100", 32'(d_x), 100);
    chk("hold_y", 32'(d_y), 32'(hy));
    chk("hold_rgb", 32'(d_rgb), 32'(hrgb));
    chk("hold_hsync", 32'(d_hs), 32'(hhs));
    chk("hold_video_on", 32'(d_vo), 32'(hvo));
    chk("hold_s_x", 32'(s_x), 32'(shx));
    chk("hold_s_tick", 32'(s_tick), 0);
    en = 1'b1;
    k = 0;
    while (d_x != 10'd101 && k < 4) begin @(posedge clk); #1; k++; end
    chk("resume_x101", 32'(d_x), 101);

    // Reset in the middle of a tiny frame
    k = 0;
    while (s_y != 10'd5 && k < 200) begin @(negedge clk); k++; end
    chk("s_reach_y5", 32'(s_y), 5);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 chk("mid_rst_s_x", 32'(s_x), 0);
    chk("mid_rst_s_y", 32'(s_y), 0);
    chk("mid_rst_s_hsync", 32'(s_hs), 1);
    chk("mid_rst_s_vsync", 32'(s_vs), 1);
    chk("mid_rst_s_rgb", 32'(s_rgb), 0);
    chk("mid_rst_s_fs", 32'(s_fs), 0);
    chk("mid_rst_d_x", 32'(d_x), 0);
    chk("mid_rst_d_y", 32'(d_y), 0);
    #1 rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
